partial_sum_gen: RTL and testbench
==================================

Name: partial_sum_gen

Overview:
- Parametrised successor of the fixed 8-macro partial-sum stage in the layer pipeline.
- Collects signed outputs from MACRO_NUM compute-in-memory macros over PASS_NUM reuse passes and adds the IN_SPLIT macros that share one output-channel group.
- Assembles a full CHANNEL_NUM-wide vector with one-cycle valid and feeds bn_res.
- New relative to the fixed version: runtime acc_mode (slice vs. deep-input accumulation), frame resync on vs, saturation, pass index output for macro bank select.

Parameters:
- MACRO_NUM, 8, number of macros.
- MACRO_CH, 64, output columns per macro.
- IN_SPLIT, 4, macros summed per channel group (input-depth split); MACRO_NUM % IN_SPLIT == 0.
- PASS_NUM, 2, macro reuse passes per output vector; GROUPS*MACRO_CH*PASS_NUM == CHANNEL_NUM.
- CHANNEL_NUM, 256, output channels in slice mode.
- IN_W, 6, signed macro output width.
- OUT_W, 16, signed output width.
- Derived: GROUPS = MACRO_NUM/IN_SPLIT; SLICE = GROUPS*MACRO_CH; SUM_W = IN_W+$clog2(IN_SPLIT)+$clog2(PASS_NUM)+1.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous reset, active-high.
- mode, in, 1, 0 = parameter reload (block idle and cleared), 1 = calculate.
- vs, in, 1, frame sync pulse; resynchronises the pass counter.
- acc_mode, in, 1, 0 = slice mode, 1 = accumulate mode; sampled only at pass 0.
- in_valid, in, 1, macro outputs valid this cycle.
- data_in, in, [MACRO_NUM][MACRO_CH] x IN_W signed, macro outputs.
- pass_idx, out, $clog2(PASS_NUM), pass expected next; drives chs_macro.
- data_out, out, [CHANNEL_NUM] x OUT_W signed, assembled vector.
- data_e_out, out, 1, one-cycle pulse: data_out valid.

Behaviour:
- Reset values: all outputs 0; pass counter 0; pipeline valids 0; bank cleared.
- mode=0: synchronous clear of counter, valids, bank and acc_mode latch; in_valid ignored; data_e_out=0.
- Stage 1 (registered): for each group g and column c, s1[g][c] = sum of data_in[g*IN_SPLIT+k][c] for k=0..IN_SPLIT-1, sign-extended to SUM_W. Valid and pass tag are pipelined alongside.
- Stage 2, slice mode: bank[p*SLICE + g*MACRO_CH + c] <= sat(s1[g][c]), where p is the tagged pass.
- Stage 2, accumulate mode: acc[g*MACRO_CH+c] <= (p==0 ? 0 : acc) + s1. The final result is written to bank[0..SLICE-1]; bank[SLICE..CHANNEL_NUM-1] is forced to 0.
- FSM: IDLE -> COLLECT on the first accepted beat. COLLECT counts passes; after the beat with pass == PASS_NUM-1 the counter wraps to 0 and the FSM returns to IDLE.
- pass_idx = counter. The counter increments on each accepted in_valid.
- Latency: last-pass in_valid at cycle T -> data_e_out=1 at T+2. data_out is registered and holds until the next completion, so it is stable whenever data_e_out=1.
- Saturation: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1] at the output write. In accumulate mode the accumulator is SUM_W wide and never wraps.
- vs and in_valid in the same cycle: vs clears the counter, and that beat is accepted as pass 0. vs alone mid-frame: the partial frame is discarded, no data_e_out, and the bank keeps its last complete vector.
- acc_mode change mid-frame: ignored until the next pass 0.
- Back-to-back frames with in_valid every cycle are supported, no bubbles: the stage 2 write for pass 0 of frame N+1 and the completion of frame N never collide.
- Reset asserted mid-operation: everything returns to reset values immediately; no output pulse.

Decomposition:
- Package partial_sum_gen_pkg: function sat_out(sum) and typedefs for the sum and output words, plus the derived-parameter functions (GROUPS, SLICE, SUM_W) with their legality checks.
- One sub-module, ps_group_adder: a combinational IN_SPLIT-input signed adder for one column, instantiated GROUPS*MACRO_CH times via generate. The FSM, counter and bank stay in the top.

Test Plan:
1. Reset, then mode=1, acc_mode=0. Pass 0: every macro outputs +3; pass 1: every macro outputs -2. data_e_out rises 2 cycles after pass 1. data_out[0..127]=12, data_out[128..255]=-8; pass_idx sequence 0,1,0.
2. acc_mode=1, same stimulus as 1. data_out[0..127]=4, data_out[128..255]=0.
3. Saturation with OUT_W=6, acc_mode=1: all inputs +31 for both passes. Raw sum 248 -> data_out=31; all inputs -32 -> -32.
4. vs pulse after pass 0, then a fresh pass 0 and pass 1 with +1 inputs. No pulse for the aborted frame; a single pulse follows, with data_out[0..127]=4.
5. vs coincident with in_valid carrying +5 inputs, then pass 1 with 0 inputs. That beat is treated as pass 0: data_out[0..127]=20, data_out[128..255]=0.
6. mode=0 mid-frame, and rst asserted between in_valid beats. In both cases data_e_out stays 0, pass_idx=0, and data_out clears to 0.

Source files
------------

// File: rtl/partial_sum_gen_pkg.sv
// Shared types and elaboration helpers for the partial-sum stage: derived widths,
// parameter legality and the output saturation used at the bank write.
package partial_sum_gen_pkg;

    typedef enum logic {ST_IDLE, ST_COLLECT} state_t;

    function automatic int calc_groups(input int macro_num, input int in_split);
        return macro_num / in_split;
    endfunction

    function automatic int calc_slice(input int macro_num, input int in_split, input int macro_ch);
        return calc_groups(macro_num, in_split) * macro_ch;
    endfunction

    // One extra bit on top of the split and pass growth keeps the accumulator from wrapping.
    function automatic int calc_sum_w(input int in_w, input int in_split, input int pass_num);
        return in_w + $clog2(in_split) + $clog2(pass_num) + 1;
    endfunction

    function automatic bit params_ok(input int macro_num, input int macro_ch, input int in_split,
                                     input int pass_num, input int channel_num,
                                     input int in_w, input int out_w);
        return (in_split > 0) && (macro_num % in_split == 0) && (pass_num >= 2) &&
               (macro_ch > 0) && (in_w >= 2) && (out_w >= 2) && (out_w <= 63) &&
               (calc_slice(macro_num, in_split, macro_ch) * pass_num == channel_num);
    endfunction

    localparam int DEF_SUM_W = calc_sum_w(6, 4, 2);
    localparam int DEF_OUT_W = 16;

    // Word types of the default configuration.
    typedef logic signed [DEF_SUM_W-1:0] sum_t;
    typedef logic signed [DEF_OUT_W-1:0] out_t;

    function automatic longint sat_out(input longint sum, input int out_w);
        longint hi;
        longint lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (sum > hi) return hi;
        if (sum < lo) return lo;
        return sum;
    endfunction

endpackage

// File: rtl/ps_group_adder.sv
// Combinational signed adder for one output column: sums the IN_SPLIT macros of a
// channel group after sign-extending each to SUM_W.
module ps_group_adder
    import partial_sum_gen_pkg::*;
#(
    parameter int IN_SPLIT = 4,
    parameter int IN_W     = 6,
    parameter int SUM_W    = 10
) (
    input  logic [IN_SPLIT-1:0][IN_W-1:0] din,
    output logic [SUM_W-1:0]              sum
);

    always_comb begin
        sum = '0;
        for (int k = 0; k < IN_SPLIT; k++) begin
            sum = sum + {{(SUM_W-IN_W){din[k][IN_W-1]}}, din[k]};
        end
    end

endmodule

// File: rtl/partial_sum_gen.sv
// Partial-sum stage: sums input-split macros per column, collects PASS_NUM passes
// (slice or deep accumulation) and emits a saturated CHANNEL_NUM vector with a valid pulse.
module partial_sum_gen
    import partial_sum_gen_pkg::*;
#(
    parameter int MACRO_NUM   = 8,
    parameter int MACRO_CH    = 64,
    parameter int IN_SPLIT    = 4,
    parameter int PASS_NUM    = 2,
    parameter int CHANNEL_NUM = 256,
    parameter int IN_W        = 6,
    parameter int OUT_W       = 16
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       mode,
    input  logic                                       vs,
    input  logic                                       acc_mode,
    input  logic                                       in_valid,
    input  logic [MACRO_NUM-1:0][MACRO_CH-1:0][IN_W-1:0] data_in,
    output logic [$clog2(PASS_NUM)-1:0]                pass_idx,
    output logic [CHANNEL_NUM-1:0][OUT_W-1:0]          data_out,
    output logic                                       data_e_out
);

    localparam int GROUPS = calc_groups(MACRO_NUM, IN_SPLIT);
    localparam int SLICE  = calc_slice(MACRO_NUM, IN_SPLIT, MACRO_CH);
    localparam int SUM_W  = calc_sum_w(IN_W, IN_SPLIT, PASS_NUM);
    localparam int PW     = $clog2(PASS_NUM);
    localparam int STAGES = 1;
    localparam logic [PW-1:0] LAST = PW'(PASS_NUM - 1);

    if (!params_ok(MACRO_NUM, MACRO_CH, IN_SPLIT, PASS_NUM, CHANNEL_NUM, IN_W, OUT_W)) begin : g_bad_params
        $error("partial_sum_gen: illegal parameter set");
    end

    state_t                                state, state_nxt;
    logic [PW-1:0]                         cnt, cnt_nxt, beat_pass;
    logic                                  beat;
    logic [STAGES:0]                       vld_pipe;
    logic [SLICE-1:0][SUM_W-1:0]           grp_sum, s1_sum, acc, acc_nxt;
    logic [PW-1:0]                         s1_pass;
    logic                                  s1_acc, acc_lat;
    logic [SLICE-1:0][OUT_W-1:0]           sat_s1, sat_acc;
    logic [PASS_NUM-2:0][SLICE-1:0][OUT_W-1:0] stg;
    logic [CHANNEL_NUM-1:0][OUT_W-1:0]     out_nxt;

    for (genvar g = 0; g < GROUPS; g++) begin : g_grp
        for (genvar c = 0; c < MACRO_CH; c++) begin : g_col
            logic [IN_SPLIT-1:0][IN_W-1:0] col_in;
            for (genvar k = 0; k < IN_SPLIT; k++) begin : g_k
                assign col_in[k] = data_in[g*IN_SPLIT+k][c];
            end
            ps_group_adder #(
                .IN_SPLIT(IN_SPLIT),
                .IN_W    (IN_W),
                .SUM_W   (SUM_W)
            ) u_add (
                .din(col_in),
                .sum(grp_sum[g*MACRO_CH+c])
            );
        end
    end

    // vs restarts the frame; a beat arriving with vs is pass 0 of the new frame.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        beat      = mode && in_valid;
        beat_pass = vs ? '0 : cnt;
        if (!mode) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else if (beat) begin
            if (beat_pass == LAST) begin
                cnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end else begin
                cnt_nxt   = beat_pass + 1'b1;
                state_nxt = ST_COLLECT;
            end
        end else if (vs) begin
            cnt_nxt   = '0;
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign pass_idx   = cnt;
    assign data_e_out = vld_pipe[STAGES];

    always_comb begin
        out_nxt = '0;
        for (int i = 0; i < SLICE; i++) begin
            acc_nxt[i] = (s1_pass == '0) ? s1_sum[i] : acc[i] + s1_sum[i];
            sat_s1[i]  = OUT_W'(sat_out(longint'($signed(s1_sum[i])), OUT_W));
            sat_acc[i] = OUT_W'(sat_out(longint'($signed(acc_nxt[i])), OUT_W));
        end
        if (s1_acc) begin
            out_nxt[SLICE-1:0] = sat_acc;
        end else begin
            for (int p = 0; p < PASS_NUM - 1; p++) out_nxt[p*SLICE +: SLICE] = stg[p];
            out_nxt[(PASS_NUM-1)*SLICE +: SLICE] = sat_s1;
        end
    end

    // Earlier passes land in a staging buffer so data_out only moves on completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            s1_sum   <= '0;
            s1_pass  <= '0;
            s1_acc   <= 1'b0;
            acc_lat  <= 1'b0;
            acc      <= '0;
            stg      <= '0;
            data_out <= '0;
        end else if (!mode) begin
            vld_pipe <= '0;
            s1_sum   <= '0;
            s1_pass  <= '0;
            s1_acc   <= 1'b0;
            acc_lat  <= 1'b0;
            acc      <= '0;
            stg      <= '0;
            data_out <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0] && (s1_pass == LAST), beat};
            if (beat) begin
                s1_sum  <= grp_sum;
                s1_pass <= beat_pass;
                if (beat_pass == '0) begin
                    s1_acc  <= acc_mode;
                    acc_lat <= acc_mode;
                end else begin
                    s1_acc  <= acc_lat;
                end
            end
            if (vld_pipe[0]) begin
                if (s1_acc) begin
                    acc <= acc_nxt;
                end else begin
                    for (int p = 0; p < PASS_NUM - 1; p++) begin
                        if (s1_pass == PW'(p)) stg[p] <= sat_s1;
                    end
                end
                if (s1_pass == LAST) data_out <= out_nxt;
            end
        end
    end

endmodule

// File: tb/tb_partial_sum_gen.sv
// Bench for partial_sum_gen: two instances (OUT_W 16 and 6) share stimulus and are
// compared each cycle against a frame-level reference model.
module tb_partial_sum_gen;

    localparam int MACRO_NUM   = 8;
    localparam int MACRO_CH    = 64;
    localparam int IN_SPLIT    = 4;
    localparam int PASS_NUM    = 2;
    localparam int CHANNEL_NUM = 256;
    localparam int IN_W        = 6;
    localparam int GROUPS      = MACRO_NUM / IN_SPLIT;
    localparam int SLICE       = GROUPS * MACRO_CH;
    localparam int OW_A        = 16;
    localparam int OW_B        = 6;
    localparam int PW          = $clog2(PASS_NUM);

    logic clk = 1'b0;
    logic rst, mode, vs, acc_mode, in_valid;
    logic [MACRO_NUM-1:0][MACRO_CH-1:0][IN_W-1:0] data_in;
    logic [PW-1:0] pidx_a, pidx_b;
    logic [CHANNEL_NUM-1:0][OW_A-1:0] dout_a;
    logic [CHANNEL_NUM-1:0][OW_B-1:0] dout_b;
    logic de_a, de_b;

    always #5 clk = ~clk;

    partial_sum_gen #(.MACRO_NUM(MACRO_NUM), .MACRO_CH(MACRO_CH), .IN_SPLIT(IN_SPLIT),
        .PASS_NUM(PASS_NUM), .CHANNEL_NUM(CHANNEL_NUM), .IN_W(IN_W), .OUT_W(OW_A)) dut_a (
        .clk(clk), .rst(rst), .mode(mode), .vs(vs), .acc_mode(acc_mode), .in_valid(in_valid),
        .data_in(data_in), .pass_idx(pidx_a), .data_out(dout_a), .data_e_out(de_a));

    partial_sum_gen #(.MACRO_NUM(MACRO_NUM), .MACRO_CH(MACRO_CH), .IN_SPLIT(IN_SPLIT),
        .PASS_NUM(PASS_NUM), .CHANNEL_NUM(CHANNEL_NUM), .IN_W(IN_W), .OUT_W(OW_B)) dut_b (
        .clk(clk), .rst(rst), .mode(mode), .vs(vs), .acc_mode(acc_mode), .in_valid(in_valid),
        .data_in(data_in), .pass_idx(pidx_b), .data_out(dout_b), .data_e_out(de_b));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int din[MACRO_NUM][MACRO_CH];
    int psum[PASS_NUM][SLICE];
    int cur_a[CHANNEL_NUM], cur_b[CHANNEL_NUM];
    int pend_a[CHANNEL_NUM], pend_b[CHANNEL_NUM];
    int m_cnt;
    bit m_acc;
    bit pend;
    int pend_due;

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int sat(input int v, input int ow);
        int hi;
        hi = (1 << (ow - 1)) - 1;
        if (v > hi) return hi;
        if (v < -hi - 1) return -hi - 1;
        return v;
    endfunction

    task automatic model_clear();
        m_cnt = 0;
        m_acc = 1'b0;
        pend  = 1'b0;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            cur_a[i] = 0;
            cur_b[i] = 0;
        end
    endtask

    task automatic finish_frame();
        int raw;
        for (int ch = 0; ch < CHANNEL_NUM; ch++) begin
            raw = 0;
            if (m_acc) begin
                if (ch < SLICE) for (int p = 0; p < PASS_NUM; p++) raw += psum[p][ch];
            end else begin
                raw = psum[ch / SLICE][ch % SLICE];
            end
            pend_a[ch] = sat(raw, OW_A);
            pend_b[ch] = sat(raw, OW_B);
        end
        pend     = 1'b1;
        pend_due = cyc + 2;
    endtask

    task automatic check_outputs();
        bit ep;
        int ia, ib;
        ep = pend && (pend_due == cyc);
        if (ep) begin
            cur_a = pend_a;
            cur_b = pend_b;
            pend  = 1'b0;
        end
        chk("data_e_out_a", de_a, ep);
        chk("data_e_out_b", de_b, ep);
        chk("pass_idx_a", pidx_a, m_cnt);
        chk("pass_idx_b", pidx_b, m_cnt);
        ia = 0;
        ib = 0;
        for (int i = CHANNEL_NUM - 1; i >= 0; i--) begin
            if ($signed(dout_a[i]) !== cur_a[i]) ia = i;
            if ($signed(dout_b[i]) !== cur_b[i]) ib = i;
        end
        chk("data_out_a", $signed(dout_a[ia]), cur_a[ia]);
        chk("data_out_b", $signed(dout_b[ib]), cur_b[ib]);
    endtask

    task automatic drive(input bit i_mode, input bit i_vs, input bit i_acc, input bit i_valid);
        int p, s;
        mode = i_mode; vs = i_vs; acc_mode = i_acc; in_valid = i_valid;
        for (int m = 0; m < MACRO_NUM; m++)
            for (int c = 0; c < MACRO_CH; c++) data_in[m][c] = IN_W'(din[m][c]);
        if (!i_mode) begin
            model_clear();
        end else begin
            if (i_vs) m_cnt = 0;
            if (i_valid) begin
                p = m_cnt;
                if (p == 0) m_acc = i_acc;
                for (int g = 0; g < GROUPS; g++)
                    for (int c = 0; c < MACRO_CH; c++) begin
                        s = 0;
                        for (int k = 0; k < IN_SPLIT; k++) s += din[g*IN_SPLIT+k][c];
                        psum[p][g*MACRO_CH+c] = s;
                    end
                if (p == PASS_NUM - 1) begin
                    finish_frame();
                    m_cnt = 0;
                end else begin
                    m_cnt = p + 1;
                end
            end
        end
        @(negedge clk);
        cyc++;
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1; mode = 1'b0; vs = 1'b0; acc_mode = 1'b0; in_valid = 1'b0;
        model_clear();
        @(negedge clk);
        cyc++;
        check_outputs();
        rst = 1'b0;
    endtask

    task automatic set_all(input int v);
        for (int m = 0; m < MACRO_NUM; m++)
            for (int c = 0; c < MACRO_CH; c++) din[m][c] = v;
    endtask

    task automatic set_rand();
        for (int m = 0; m < MACRO_NUM; m++)
            for (int c = 0; c < MACRO_CH; c++) din[m][c] = int'($urandom_range(63)) - 32;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        set_all(0);
        do_reset();
        do_reset();

        // slice mode: +3 then -2
        set_all(3);  drive(1, 0, 0, 1);
        set_all(-2); drive(1, 0, 0, 1);
        idle(3);
        // accumulate mode, same stimulus
        set_all(3);  drive(1, 0, 1, 1);
        set_all(-2); drive(1, 0, 1, 1);
        idle(3);
        // saturation at both extremes
        set_all(31);  drive(1, 0, 1, 1); drive(1, 0, 1, 1); idle(3);
        set_all(-32); drive(1, 0, 1, 1); drive(1, 0, 1, 1); idle(3);
        // vs abort after pass 0, then a clean frame
        set_all(7); drive(1, 0, 0, 1);
        drive(1, 1, 0, 0);
        idle(2);
        set_all(1); drive(1, 0, 0, 1); drive(1, 0, 0, 1);
        idle(3);
        // vs coincident with a beat mid-frame
        set_all(9); drive(1, 0, 1, 1);
        set_all(5); drive(1, 1, 1, 1);
        set_all(0); drive(1, 0, 1, 1);
        idle(3);
        // acc_mode flips mid-frame
        set_rand(); drive(1, 0, 0, 1);
        set_rand(); drive(1, 0, 1, 1);
        idle(3);
        // back-to-back frames, no bubbles
        for (int i = 0; i < 8; i++) begin
            set_rand();
            drive(1, 0, (i / 2) % 2 == 1, 1);
        end
        idle(3);
        // mode=0 mid-frame with in_valid high
        set_rand(); drive(1, 0, 0, 1);
        drive(0, 0, 0, 1);
        idle(3);
        // reset between beats of a frame
        set_rand(); drive(1, 0, 1, 1); drive(1, 0, 1, 1);
        set_rand(); drive(1, 0, 1, 1);
        do_reset();
        idle(2);
        set_rand(); drive(1, 0, 0, 1); drive(1, 0, 0, 1);
        idle(3);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_rand();
            drive(($urandom % 50) != 0, ($urandom % 16) == 0, $urandom % 2 == 1, ($urandom % 4) != 0);
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
